operand_regfile: RTL and testbench

Operand-fetch and architectural-state stage sitting directly upstream of the 16-bit ALU in the single-cycle core. It holds the general-purpose register file and the NZCV flags register. It drives the ALU's A_in, B_in and AddSubCBin operands, and captures the ALU result and FlagsNZCV at the end of each instruction cycle. It also evaluates the 4-bit branch/predication condition against the stored flags.

---
 rtl/operand_regfile_if.sv | 35 +++
 rtl/operand_regfile.sv | 94 +++++++++
 tb/tb_operand_regfile.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_regfile_if.sv
// Operand-fetch bus between the decoder/write-back side (master) and the
// register file (slave): read addresses, operands, write-back, flags, condition.
interface operand_regfile_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic [REG_AW-1:0] rd_addr_a;
  logic [REG_AW-1:0] rd_addr_b;
  logic [DATA_W-1:0] imm;
  logic              imm_sel;
  logic              carry_use;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic              AddSubCBin;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flags_we;
  logic [3:0]        flags_in;
  logic [3:0]        flags_out;
  logic [3:0]        cond;
  logic              cond_true;

  modport master (
    output rd_addr_a, rd_addr_b, imm, imm_sel, carry_use,
    output wr_en, wr_addr, wr_data, flags_we, flags_in, cond,
    input  A_in, B_in, AddSubCBin, flags_out, cond_true
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, imm, imm_sel, carry_use,
    input  wr_en, wr_addr, wr_data, flags_we, flags_in, cond,
    output A_in, B_in, AddSubCBin, flags_out, cond_true
  );
endinterface

// File: rtl/operand_regfile.sv
// Register file + NZCV flags feeding the ALU, with condition-code evaluation.
// Optional build macro R0_ZERO_EN hardwires r0 to zero.
module operand_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input logic               clk,
  input logic               rst,
  operand_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [3:0]        flags_q;
  logic [3:0]        flags_d;
  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_reg_s;
  logic              cond_s;

  // An address names real storage only if it is in range (and not r0 when hardwired).
  function automatic logic addr_live(input logic [REG_AW-1:0] a);
`ifdef R0_ZERO_EN
    addr_live = (32'(a) < 32'(NREGS)) && (a != '0);
`else
    addr_live = (32'(a) < 32'(NREGS));
`endif
  endfunction

  // Read ports: purely from stored state, never bypassed from wr_data (ALU loop).
  always_comb begin
    a_s     = '0;
    b_reg_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      a_s     = (addr_live(REG_AW'(i)) && (bus.rd_addr_a == REG_AW'(i))) ? regs_q[i] : a_s;
      b_reg_s = (addr_live(REG_AW'(i)) && (bus.rd_addr_b == REG_AW'(i))) ? regs_q[i] : b_reg_s;
    end
  end

  // Next state for register array and flags.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (bus.wr_en && (bus.wr_addr == REG_AW'(i)) && addr_live(REG_AW'(i)))
                  ? bus.wr_data : regs_q[i];
    end
    flags_d = bus.flags_we ? bus.flags_in : flags_q;
  end

  // State update; reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      flags_q <= 4'b0000;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      flags_q <= flags_d;
    end
  end

  // Condition code against stored flags: [3]=N [2]=Z [1]=C [0]=V.
  always_comb begin
    cond_s = 1'b0;
    case (bus.cond)
      4'b0000: cond_s = flags_q[2];
      4'b0001: cond_s = !flags_q[2];
      4'b0010: cond_s = flags_q[1];
      4'b0011: cond_s = !flags_q[1];
      4'b0100: cond_s = flags_q[3];
      4'b0101: cond_s = !flags_q[3];
      4'b0110: cond_s = flags_q[0];
      4'b0111: cond_s = !flags_q[0];
      4'b1000: cond_s = flags_q[1] && !flags_q[2];
      4'b1001: cond_s = !flags_q[1] || flags_q[2];
      4'b1010: cond_s = (flags_q[3] == flags_q[0]);
      4'b1011: cond_s = (flags_q[3] != flags_q[0]);
      4'b1100: cond_s = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'b1101: cond_s = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'b1110: cond_s = 1'b1;
      4'b1111: cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
  end

  assign bus.A_in       = a_s;
  assign bus.B_in       = bus.imm_sel ? bus.imm : b_reg_s;
  assign bus.AddSubCBin = bus.carry_use & flags_q[1];
  assign bus.flags_out  = flags_q;
  assign bus.cond_true  = cond_s;

endmodule

// File: tb/tb_operand_regfile.sv
// Self-checking bench for operand_regfile: directed vector table, condition
// sweep, and randomized traffic against an array-based reference model.
module tb_operand_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  operand_regfile_if #(.DATA_W(16), .REG_AW(3)) bus ();

  operand_regfile #(.DATA_W(16), .NREGS(8), .REG_AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    logic        imm_sel;
    logic        carry_use;
    logic [3:0]  cond;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_c;
    logic [3:0]  exp_f;
    logic        exp_ct;
  } vec_t;

  vec_t vecs [17];

  // reference model state
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;

  function automatic vec_t mk(
      input logic r, input logic we, input logic [2:0] wa, input logic [15:0] wd,
      input logic fwe, input logic [3:0] fin, input logic [2:0] ra, input logic [2:0] rb,
      input logic [15:0] imm, input logic isel, input logic cu, input logic [3:0] cnd,
      input logic [15:0] ea, input logic [15:0] eb, input logic ec, input logic [3:0] ef,
      input logic ect);
    vec_t v;
    v.rst = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.flags_we = fwe; v.flags_in = fin; v.ra = ra; v.rb = rb;
    v.imm = imm; v.imm_sel = isel; v.carry_use = cu; v.cond = cnd;
    v.exp_a = ea; v.exp_b = eb; v.exp_c = ec; v.exp_f = ef; v.exp_ct = ect;
    return v;
  endfunction

  // Condition truth from the ISA table: pair predicate, odd code is its negation.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic [7:0] preds;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    preds = {1'b1, (!z && (n == v)), (n == v), (cy && !z), v, n, cy, z};
    return preds[c[3:1]] ^ c[0];
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    return (R0Z && a == 3'd0) ? 16'h0000 : m_regs[a];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.wr_en     = v.wr_en;
    bus.wr_addr   = v.wr_addr;
    bus.wr_data   = v.wr_data;
    bus.flags_we  = v.flags_we;
    bus.flags_in  = v.flags_in;
    bus.rd_addr_a = v.ra;
    bus.rd_addr_b = v.rb;
    bus.imm       = v.imm;
    bus.imm_sel   = v.imm_sel;
    bus.carry_use = v.carry_use;
    bus.cond      = v.cond;
  endtask

  task automatic model_edge(input vec_t v);
    if (v.rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_flags = 4'b0000;
    end else begin
      if (v.wr_en && !(R0Z && v.wr_addr == 3'd0)) m_regs[v.wr_addr] = v.wr_data;
      if (v.flags_we) m_flags = v.flags_in;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".A_in"}, bus.A_in, m_read(bus.rd_addr_a));
    check({tag, ".B_in"}, bus.B_in, bus.imm_sel ? bus.imm : m_read(bus.rd_addr_b));
    check({tag, ".cbin"}, {15'd0, bus.AddSubCBin}, {15'd0, bus.carry_use & m_flags[1]});
    check({tag, ".flags"}, {12'd0, bus.flags_out}, {12'd0, m_flags});
    check({tag, ".cond"}, {15'd0, bus.cond_true}, {15'd0, cond_ref(bus.cond, m_flags)});
  endtask

  vec_t idle;
  vec_t rv;
  logic [15:0] r0_exp;
  logic [3:0]  sweep_f [5];

  initial begin
    idle = mk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 4'h0,
              16'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    r0_exp = R0Z ? 16'h0000 : 16'h5555;

    //        rst  we   wa    wdata     fwe  fin    ra    rb    imm       isel cu   cond   expA      expB      eC   eF     eCT
    vecs[0]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0,3'd0,16'h0000,1'b0,1'b0,4'd1, 16'h0000,16'h0000,1'b0,4'h0,1'b1);
    vecs[1]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0,3'd0,16'h7777,1'b1,1'b1,4'd0, 16'h0000,16'h7777,1'b0,4'h0,1'b0);
    vecs[2]  = mk(1'b0,1'b1,3'd3,16'h1234,1'b0,4'h0,3'd3,3'd0,16'h0000,1'b0,1'b0,4'd14,16'h0000,16'h0000,1'b0,4'h0,1'b1);
    vecs[3]  = mk(1'b0,1'b1,3'd5,16'h00FF,1'b0,4'h0,3'd3,3'd5,16'h0000,1'b0,1'b0,4'd0, 16'h1234,16'h0000,1'b0,4'h0,1'b0);
    vecs[4]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd3,3'd5,16'h0000,1'b0,1'b0,4'd5, 16'h1234,16'h00FF,1'b0,4'h0,1'b1);
    vecs[5]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd3,3'd5,16'hBEEF,1'b1,1'b0,4'd4, 16'h1234,16'hBEEF,1'b0,4'h0,1'b0);
    vecs[6]  = mk(1'b0,1'b1,3'd2,16'h0001,1'b0,4'h0,3'd2,3'd3,16'h0000,1'b0,1'b0,4'd15,16'h0000,16'h1234,1'b0,4'h0,1'b0);
    vecs[7]  = mk(1'b0,1'b1,3'd2,16'h0002,1'b0,4'h0,3'd2,3'd2,16'h0000,1'b0,1'b0,4'd14,16'h0001,16'h0001,1'b0,4'h0,1'b1);
    vecs[8]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b1,4'h2,3'd2,3'd2,16'h0000,1'b0,1'b1,4'd2, 16'h0002,16'h0002,1'b0,4'h0,1'b0);
    vecs[9]  = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'hF,3'd2,3'd5,16'h0000,1'b0,1'b1,4'd2, 16'h0002,16'h00FF,1'b1,4'h2,1'b1);
    vecs[10] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd3,3'd5,16'h0000,1'b0,1'b0,4'd3, 16'h1234,16'h00FF,1'b0,4'h2,1'b0);
    vecs[11] = mk(1'b1,1'b1,3'd1,16'hAAAA,1'b1,4'hF,3'd1,3'd3,16'h0000,1'b0,1'b1,4'd9, 16'h0000,16'h1234,1'b1,4'h2,1'b0);
    vecs[12] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd1,3'd3,16'h0000,1'b0,1'b1,4'd9, 16'h0000,16'h0000,1'b0,4'h0,1'b1);
    vecs[13] = mk(1'b0,1'b1,3'd0,16'h5555,1'b0,4'h0,3'd0,3'd0,16'h0000,1'b0,1'b0,4'd15,16'h0000,16'h0000,1'b0,4'h0,1'b0);
    vecs[14] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd0,3'd0,16'h0000,1'b0,1'b0,4'd14,r0_exp,  r0_exp,  1'b0,4'h0,1'b1);
    vecs[15] = mk(1'b0,1'b1,3'd4,16'hC3C3,1'b1,4'h8,3'd4,3'd0,16'h0000,1'b0,1'b0,4'd10,16'h0000,r0_exp,  1'b0,4'h0,1'b1);
    vecs[16] = mk(1'b0,1'b0,3'd0,16'h0000,1'b0,4'h0,3'd4,3'd0,16'h0000,1'b0,1'b1,4'd10,16'hC3C3,r0_exp,  1'b0,4'h8,1'b0);

    // initial reset, two edges
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // directed table
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #2;
      check($sformatf("vec%0d.A_in", k), bus.A_in, vecs[k].exp_a);
      check($sformatf("vec%0d.B_in", k), bus.B_in, vecs[k].exp_b);
      check($sformatf("vec%0d.cbin", k), {15'd0, bus.AddSubCBin}, {15'd0, vecs[k].exp_c});
      check($sformatf("vec%0d.flags", k), {12'd0, bus.flags_out}, {12'd0, vecs[k].exp_f});
      check($sformatf("vec%0d.cond", k), {15'd0, bus.cond_true}, {15'd0, vecs[k].exp_ct});
      @(posedge clk);
    end

    // sync model with a reset, then cond sweep over the listed flag patterns
    @(negedge clk);
    rv = idle; rv.rst = 1'b1;
    drive(rv);
    @(posedge clk);
    model_edge(rv);
    sweep_f[0] = 4'b0000; sweep_f[1] = 4'b0100; sweep_f[2] = 4'b1001;
    sweep_f[3] = 4'b0010; sweep_f[4] = 4'b1000;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      rv = idle; rv.flags_we = 1'b1; rv.flags_in = sweep_f[s];
      drive(rv);
      @(posedge clk);
      model_edge(rv);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rv = idle; rv.cond = 4'(c); rv.flags_in = 4'hF;
        drive(rv);
        #2;
        check($sformatf("sweep f=%b c=%0d", sweep_f[s], c),
              {15'd0, bus.cond_true}, {15'd0, cond_ref(4'(c), sweep_f[s])});
        @(posedge clk);
      end
    end

    // randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      rv.rst       = ($urandom_range(0, 31) == 0);
      rv.wr_en     = $urandom_range(0, 1) == 1;
      rv.wr_addr   = 3'($urandom_range(0, 7));
      rv.wr_data   = 16'($urandom);
      rv.flags_we  = $urandom_range(0, 2) == 0;
      rv.flags_in  = 4'($urandom_range(0, 15));
      rv.ra        = 3'($urandom_range(0, 7));
      rv.rb        = 3'($urandom_range(0, 7));
      rv.imm       = 16'($urandom);
      rv.imm_sel   = $urandom_range(0, 3) == 0;
      rv.carry_use = $urandom_range(0, 1) == 1;
      rv.cond      = 4'($urandom_range(0, 15));
      drive(rv);
      #2;
      check_model($sformatf("rand%0d", t));
      @(posedge clk);
      model_edge(rv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
